ro_response_reader: RTL and testbench
=====================================

// Module: ro_response_reader
// PURPOSE
//  Read side of the RO PUF. Applies a challenge to two inverting-slice ring-oscillator chains (A, B)
//  and enables both chains. Counts synchronized rising edges of each chain over a fixed window.
//  Emits a 1-bit response, RESP = (count A > count B), through a valid/ack handshake.
//  Sits between the challenge source/encryption logic and the RO chain pair.
// PARAMETERS
//  CHAL_W  8     challenge width; one select bit per slice stage
//  CNT_W   16    edge-counter width; counters saturate at 2^CNT_W-1
//  SETTLE  16    cycles RO_EN is high before counting starts (>=1)
//  WINDOW  4096  measurement window in CLK cycles (>=1)
// PORTS
//  CLK         in   1       system clock
//  RST         in   1       synchronous, active-high reset
//  START       in   1       request a measurement; sampled only in IDLE
//  CHALLENGE   in   CHAL_W  challenge; latched when START is accepted
//  RO_SEL      out  CHAL_W  latched challenge driven to both chains' SEL inputs
//  RO_EN       out  1       ring enable for both chains
//  RO_A        in   1       chain A output (asynchronous)
//  RO_B        in   1       chain B output (asynchronous)
//  BUSY        out  1       high in every state except IDLE
//  RESP        out  1       response bit; meaningful while RESP_VALID
//  RESP_TIE    out  1       counts were equal; RESP is forced to 0
//  RESP_VALID  out  1       response available; held until RESP_ACK
//  RESP_ACK    in   1       consumer accepts the response
//  COUNT_A     out  CNT_W   final count, chain A; held until next START
//  COUNT_B     out  CNT_W   final count, chain B; held until next START
// BEHAVIOUR
//  - Reset: every output is 0; FSM goes to IDLE; synchronizers and counters are cleared.
//    RST mid-operation aborts and drops RO_EN on the next edge.
//  - FSM: IDLE -> SETTLE -> MEASURE -> COMPARE -> HOLD -> IDLE.
//  - IDLE -> SETTLE: START=1. Latch RO_SEL<=CHALLENGE, set RO_EN<=1, clear counters and COUNT_A/B.
//  - SETTLE: lasts SETTLE cycles; counting disabled.
//  - MEASURE: lasts WINDOW cycles; counting enabled. RO_EN<=0 on exit.
//  - COMPARE: 1 cycle. COUNT_A/B<=counters; RESP<=(A>B); RESP_TIE<=(A==B).
//  - HOLD: RESP_VALID=1 until RESP_ACK is sampled high, then IDLE next cycle.
//    RESP/RESP_TIE/COUNT_* are unchanged through HOLD and IDLE.
//  - Latency: RESP_VALID rises SETTLE+WINDOW+2 cycles after the START edge.
//  - START is ignored while BUSY. START in the same cycle as the ACK that leaves HOLD is ignored.
//  - RESP_ACK outside HOLD is ignored.
//  - Edge counting: 2-FF synchronizer, then rising-edge detect, per chain.
//    The synchronizer adds 2 cycles of delay, so an edge within 2 cycles of a window boundary
//    may fall either side of it.
//  - Inputs must toggle slower than CLK/2; faster inputs alias.
//  - Counters saturate, never wrap. Both saturated -> tie.
// CONFIGURATION
//  Macro RO_TIE_RETRY_EN:
//  - Defined: a tie in COMPARE re-enters SETTLE, same RO_SEL, counters cleared, up to 3 retries.
//    A 4th tie sets RESP=0, RESP_TIE=1 and goes to HOLD.
//    Each retry adds SETTLE+WINDOW+1 cycles of latency.
//  - Undefined: a tie goes straight to HOLD with RESP=0, RESP_TIE=1.
// STRUCTURE
//  - Package ro_puf_pkg: FSM state enum typedef; MAX_TIE_RETRY=3 constant.
//  - Sub-module ro_edge_counter (CNT_W): sync + edge detect + saturating counter with clr/en.
//    Instantiated twice, for A and B.
// TESTING (bench params: SETTLE=4, WINDOW=64, CNT_W=8)
//  - RO_A rises every 4 clk, RO_B every 8 clk, START with CHALLENGE=8'hA5
//    -> RO_SEL=8'hA5; VALID at cycle 70; COUNT_A=16, COUNT_B=8; RESP=1, TIE=0.
//  - Swap the two rates -> RESP=0, TIE=0, COUNT_A=8, COUNT_B=16.
//  - Equal rates (every 4 clk, in phase) -> RESP=0, TIE=1.
//    With RO_TIE_RETRY_EN: BUSY lasts 4 measurements, VALID at cycle 277.
//  - RO_A rises every 2 clk with CNT_W=4 -> COUNT_A=15 (saturated); RO_B every 8 clk -> RESP=1.
//  - RST at cycle 30 of MEASURE -> next cycle RO_EN=0, BUSY=0, COUNT_*=0; a fresh START completes normally.
//  - START pulsed while BUSY; RESP_ACK withheld 10 cycles -> second START has no effect;
//    VALID/RESP stable for 10 cycles; IDLE the cycle after ACK.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types for the RO PUF read side.
// FSM state encoding and tie-retry limit.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_COMPARE,
        ST_HOLD
    } state_t;

    localparam int MAX_TIE_RETRY = 3;

endpackage

// File: rtl/ro_response_reader_if.sv
// Request/response bundle between the challenge source and the reader.
// master = challenge source / consumer, slave = ro_response_reader.
interface ro_response_reader_if #(
    parameter int CHAL_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CHAL_W-1:0] challenge;
    logic              busy;
    logic              resp;
    logic              resp_tie;
    logic              resp_valid;
    logic              resp_ack;
    logic [CNT_W-1:0]  count_a;
    logic [CNT_W-1:0]  count_b;

    modport master (
        output start, challenge, resp_ack,
        input  busy, resp, resp_tie, resp_valid, count_a, count_b
    );

    modport slave (
        input  start, challenge, resp_ack,
        output busy, resp, resp_tie, resp_valid, count_a, count_b
    );

endinterface

// File: rtl/ro_edge_counter.sv
// Per-chain edge counter: 2-FF synchronizer, rising-edge detect,
// saturating counter with synchronous clear and count enable.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [2:0] sync;
    logic       rise;

    // sync[1:0] is the synchronizer, sync[2] the previous synced level
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], ro};
    end

    assign rise = sync[1] & ~sync[2];

    // count detected edges, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && rise && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ro_response_reader.sv
// RO PUF read side: settle, count both chains, compare, hand off RESP.
// Build option: define RO_TIE_RETRY_EN to re-measure on ties (up to 3x).
module ro_response_reader #(
    parameter int CHAL_W = 8,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 16,
    parameter int WINDOW = 4096
) (
    input  logic              clk,
    input  logic              rst,
    ro_response_reader_if.slave bus,
    output logic [CHAL_W-1:0] ro_sel,
    output logic              ro_en,
    input  logic              ro_a,
    input  logic              ro_b
);
    import ro_puf_pkg::*;

    localparam int TMAX  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             cnt_clr;
    logic             cnt_en;

`ifdef RO_TIE_RETRY_EN
    localparam int RTY_W = $clog2(MAX_TIE_RETRY + 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_TIE_RETRY);
    logic [RTY_W-1:0] retry;
`endif

    // counters are held clear while settling and run only in the window
    assign cnt_clr = (state == ST_SETTLE);
    assign cnt_en  = (state == ST_MEASURE);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .ro  (ro_a),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .ro  (ro_b),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_b)
    );

    // measurement sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            timer          <= '0;
            ro_sel         <= '0;
            ro_en          <= 1'b0;
            bus.busy       <= 1'b0;
            bus.resp       <= 1'b0;
            bus.resp_tie   <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.count_a    <= '0;
            bus.count_b    <= '0;
`ifdef RO_TIE_RETRY_EN
            retry          <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        ro_sel      <= bus.challenge;
                        ro_en       <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.count_a <= '0;
                        bus.count_b <= '0;
                        timer       <= SETTLE_LD;
                        state       <= ST_SETTLE;
`ifdef RO_TIE_RETRY_EN
                        retry       <= '0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (timer == '0) begin
                        timer <= WINDOW_LD;
                        state <= ST_MEASURE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (timer == '0) begin
                        ro_en <= 1'b0;
                        state <= ST_COMPARE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_COMPARE: begin
                    bus.count_a <= cnt_a;
                    bus.count_b <= cnt_b;
                    if (cnt_a != cnt_b) begin
                        bus.resp       <= (cnt_a > cnt_b);
                        bus.resp_tie   <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        state          <= ST_HOLD;
`ifdef RO_TIE_RETRY_EN
                    end else if (retry < RETRY_MAX) begin
                        retry <= retry + 1'b1;
                        ro_en <= 1'b1;
                        timer <= SETTLE_LD;
                        state <= ST_SETTLE;
`endif
                    end else begin
                        bus.resp       <= 1'b0;
                        bus.resp_tie   <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state          <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.resp_ack) begin
                        bus.resp_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_response_reader.sv
// Bench for ro_response_reader (SETTLE=4, WINDOW=64, CNT_W=8 and 4).
// Honours RO_TIE_RETRY_EN when checking tie latency.
module tb_ro_response_reader;

    localparam int S = 4;
    localparam int W = 64;
`ifdef RO_TIE_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;
    logic [7:0] ro_sel;
    logic       ro_en;
    logic [7:0] ro_sel4;
    logic       ro_en4;

    int checks = 0;
    int errors = 0;

    // ring oscillator models: free-running, period in clk cycles
    int pa = 4;
    int pb = 8;
    int ca = 0;
    int cb = 0;

    ro_response_reader_if #(.CHAL_W(8), .CNT_W(8)) bus ();
    ro_response_reader_if #(.CHAL_W(8), .CNT_W(4)) bus4 ();

    ro_response_reader #(
        .CHAL_W(8), .CNT_W(8), .SETTLE(S), .WINDOW(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ro_sel (ro_sel),
        .ro_en  (ro_en),
        .ro_a   (ro_a),
        .ro_b   (ro_b)
    );

    ro_response_reader #(
        .CHAL_W(8), .CNT_W(4), .SETTLE(S), .WINDOW(W)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus4),
        .ro_sel (ro_sel4),
        .ro_en  (ro_en4),
        .ro_a   (ro_a),
        .ro_b   (ro_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ca = (ca + 1) % pa;
        cb = (cb + 1) % pb;
        ro_a = (ca < pa / 2);
        ro_b = (cb < pb / 2);
    end

    // reference model: rising edges in a W-cycle window, saturated
    function automatic int exp_cnt(int period, int cntw);
        int n;
        int sat;
        n   = W / period;
        sat = (1 << cntw) - 1;
        return (n > sat) ? sat : n;
    endfunction

    // cycles from presenting START to seeing RESP_VALID
    function automatic int exp_lat(bit tie);
        return S + W + 2 + (tie ? RETRIES * (S + W + 1) : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rates(input int a, input int b, input int pha,
                             input int phb);
        pa = a;
        pb = b;
        ca = pha;
        cb = phb;
    endtask

    // present START for one cycle, wait (bounded) for RESP_VALID
    task automatic measure(input logic [7:0] chal, output int lat);
        bus.challenge = chal;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        bus.resp_ack = 1'b1;
        tick();
        bus.resp_ack = 1'b0;
    endtask

    initial begin
        int lat;
        int ea;
        int eb;
        logic r0;
        logic [7:0] a0;
        logic [7:0] chal;

        bus.start = 1'b0;
        bus.challenge = '0;
        bus.resp_ack = 1'b0;
        bus4.start = 1'b0;
        bus4.challenge = '0;
        bus4.resp_ack = 1'b0;

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ro_en", ro_en, 0);
        chk("rst_ro_sel", ro_sel, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_resp", bus.resp, 0);
        chk("rst_tie", bus.resp_tie, 0);
        chk("rst_cnt_a", bus.count_a, 0);
        chk("rst_cnt_b", bus.count_b, 0);

        // A every 4, B every 8
        set_rates(4, 8, 1, 3);
        measure(8'hA5, lat);
        chk("t1_lat", lat, exp_lat(0));
        chk("t1_sel", ro_sel, 8'hA5);
        chk("t1_en", ro_en, 0);
        chk("t1_busy", bus.busy, 1);
        chk("t1_cnt_a", bus.count_a, 16);
        chk("t1_cnt_b", bus.count_b, 8);
        chk("t1_resp", bus.resp, 1);
        chk("t1_tie", bus.resp_tie, 0);
        ack();
        chk("t1_idle", bus.busy, 0);

        // swapped rates
        set_rates(8, 4, 5, 0);
        measure(8'h3C, lat);
        chk("t2_lat", lat, exp_lat(0));
        chk("t2_cnt_a", bus.count_a, 8);
        chk("t2_cnt_b", bus.count_b, 16);
        chk("t2_resp", bus.resp, 0);
        chk("t2_tie", bus.resp_tie, 0);
        ack();

        // equal rates in phase -> tie
        set_rates(4, 4, 0, 0);
        measure(8'h5A, lat);
        chk("t3_lat", lat, exp_lat(1));
        chk("t3_resp", bus.resp, 0);
        chk("t3_tie", bus.resp_tie, 1);
        chk("t3_cnt_a", bus.count_a, 16);
        ack();

        // randomized rates and challenges against the model
        for (int i = 0; i < 8; i++) begin
            int ra;
            int rb;
            ra = 2 << $urandom_range(0, 5);
            rb = 2 << $urandom_range(0, 5);
            set_rates(ra, rb, $urandom_range(0, ra - 1),
                      $urandom_range(0, rb - 1));
            chal = 8'($urandom);
            ea = exp_cnt(ra, 8);
            eb = exp_cnt(rb, 8);
            measure(chal, lat);
            chk("rnd_lat", lat, exp_lat(ea == eb));
            chk("rnd_sel", ro_sel, chal);
            chk("rnd_cnt_a", bus.count_a, ea);
            chk("rnd_cnt_b", bus.count_b, eb);
            chk("rnd_resp", bus.resp, (ea > eb));
            chk("rnd_tie", bus.resp_tie, (ea == eb));
            ack();
        end

        // saturation on the 4-bit instance
        set_rates(2, 8, 0, 2);
        bus4.challenge = 8'h11;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        lat = 1;
        while (!bus4.resp_valid && lat < 2000) begin
            tick();
            lat++;
        end
        chk("sat_lat", lat, exp_lat(0));
        chk("sat_cnt_a", bus4.count_a, exp_cnt(2, 4));
        chk("sat_cnt_b", bus4.count_b, 8);
        chk("sat_resp", bus4.resp, 1);
        chk("sat_tie", bus4.resp_tie, 0);
        bus4.resp_ack = 1'b1;
        tick();
        bus4.resp_ack = 1'b0;
        chk("sat_idle", bus4.busy, 0);

        // reset 30 cycles into the window, then a clean run
        set_rates(4, 8, 0, 0);
        measure(8'h77, lat);
        ack();
        bus.challenge = 8'h42;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (S + 30) tick();
        chk("ab_en_before", ro_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_en", ro_en, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_cnt_a", bus.count_a, 0);
        chk("ab_cnt_b", bus.count_b, 0);
        tick();
        measure(8'h42, lat);
        chk("ab2_lat", lat, exp_lat(0));
        chk("ab2_cnt_a", bus.count_a, 16);
        chk("ab2_resp", bus.resp, 1);
        ack();

        // START and ACK while busy are ignored; ACK withheld 10 cycles
        bus.challenge = 8'hC3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 2000) begin
            tick();
            lat++;
            if (lat == 20) begin
                bus.start = 1'b1;
                bus.challenge = 8'hFF;
                bus.resp_ack = 1'b1;
            end else if (lat == 21) begin
                bus.start = 1'b0;
                bus.resp_ack = 1'b0;
            end
        end
        chk("bz_lat", lat, exp_lat(0));
        chk("bz_sel", ro_sel, 8'hC3);
        r0 = bus.resp;
        a0 = bus.count_a;
        chk("bz_resp", r0, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bz_hold_valid", bus.resp_valid, 1);
            chk("bz_hold_resp", bus.resp, r0);
            chk("bz_hold_cnt", bus.count_a, a0);
        end
        bus.resp_ack = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.resp_ack = 1'b0;
        bus.start = 1'b0;
        chk("bz_idle_busy", bus.busy, 0);
        chk("bz_idle_valid", bus.resp_valid, 0);
        tick();
        chk("bz_no_restart", bus.busy, 0);
        chk("bz_idle_en", ro_en, 0);
        chk("bz_idle_resp", bus.resp, r0);
        chk("bz_idle_cnt", bus.count_a, a0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
